// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch, conditional branch, load and halt
// T-step sequences driving the one-hot bus/enable vectors of the datapath.
module control_sequencer #(
  parameter int             SEL_W    = 32,
  parameter int             EN_W     = 32,
  parameter logic [4:0]     ALU_INC  = 5'd14,
  parameter logic [4:0]     ALU_ADD  = 5'd3,
  parameter logic [4:0]     OP_BR    = 5'b10010,
  parameter logic [4:0]     OP_LD    = 5'b00000,
  parameter logic [4:0]     OP_HALT  = 5'b11011,
  parameter int             MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             mem_ready,
  output logic [SEL_W-1:0] bus_select,
  output logic [EN_W-1:0]  reg_enable,
  output logic [4:0]       alu_op,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             rin,
  output logic             rout,
  output logic             ba_out,
  output logic             md_read,
  output logic             read_ram,
  output logic             write_ram,
  output logic [3:0]       step,
  output logic             halted,
  output logic             fault
);

  localparam logic [3:0] S_IDLE  = 4'd0,  S_T0  = 4'd1,  S_T1  = 4'd2,
                         S_T2    = 4'd3,  S_BR3 = 4'd4,  S_BR4 = 4'd5,
                         S_BR5   = 4'd6,  S_BR6 = 4'd7,  S_LD3 = 4'd8,
                         S_LD4   = 4'd9,  S_LD5 = 4'd10, S_LD6 = 4'd11,
                         S_LD7   = 4'd12, S_HALT = 4'd13, S_FAULT = 4'd14;

  localparam int             WCW       = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  logic [3:0]       state, next_state;
  logic [WCW-1:0]   wait_cnt, next_wait;
  logic [SEL_W-1:0] bs_d;
  logic [EN_W-1:0]  re_d, re_q;
  logic [4:0]       alu_d;
  logic [3:0]       step_d;
  logic             gra_d, grb_d, rin_d, rout_d, ba_out_d, md_read_d, read_ram_d;
  logic             unused_ir;

  assign unused_ir = ^ir[26:0];
  assign grc       = 1'b0;
  assign write_ram = 1'b0;

  always_comb begin
    next_state = state;
    next_wait  = wait_cnt;
    case (state)
      S_IDLE:  if (run) next_state = S_T0;
      S_T0:    next_state = S_T1;
      S_T1, S_LD6: begin
        if (mem_ready) begin
          next_state = (state == S_T1) ? S_T2 : S_LD7;
          next_wait  = '0;
        end else begin
          next_wait = wait_cnt + WCW'(1);
          if (wait_cnt == WAIT_LAST) next_state = S_FAULT;
        end
      end
      S_T2: begin
        if (ir[31:27] == OP_HALT)    next_state = S_HALT;
        else if (ir[31:27] == OP_BR) next_state = S_BR3;
        else if (ir[31:27] == OP_LD) next_state = S_LD3;
        else                         next_state = S_T0;
      end
      S_BR3:   next_state = S_BR4;
      S_BR4:   next_state = S_BR5;
      S_BR5:   next_state = S_BR6;
      S_BR6:   next_state = S_T0;
      S_LD3:   next_state = S_LD4;
      S_LD4:   next_state = S_LD5;
      S_LD5:   next_state = S_LD6;
      S_LD7:   next_state = S_T0;
      S_HALT:  next_state = S_HALT;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered;
  // con_ff is therefore sampled on the edge leaving branch T5.
  always_comb begin
    bs_d = '0; re_d = '0; alu_d = '0; step_d = 4'hF;
    gra_d = 1'b0; grb_d = 1'b0; rin_d = 1'b0; rout_d = 1'b0;
    ba_out_d = 1'b0; md_read_d = 1'b0; read_ram_d = 1'b0;
    case (next_state)
      S_T0:  begin step_d = 4'd0; bs_d[20] = 1'b1; re_d[25] = 1'b1; re_d[18] = 1'b1; alu_d = ALU_INC; end
      S_T1:  begin step_d = 4'd1; bs_d[19] = 1'b1; re_d[20] = 1'b1; re_d[21] = 1'b1;
                   md_read_d = 1'b1; read_ram_d = 1'b1; end
      S_T2:  begin step_d = 4'd2; bs_d[21] = 1'b1; re_d[24] = 1'b1; end
      S_BR3: begin step_d = 4'd3; gra_d = 1'b1; rout_d = 1'b1; bs_d[0] = 1'b1; re_d[27] = 1'b1; end
      S_BR4: begin step_d = 4'd4; bs_d[20] = 1'b1; re_d[19] = 1'b1; end
      S_BR5: begin step_d = 4'd5; bs_d[23] = 1'b1; alu_d = ALU_ADD; re_d[18] = 1'b1; end
      S_BR6: begin
        step_d = 4'd6;
        if (con_ff) begin bs_d[19] = 1'b1; re_d[20] = 1'b1; end
      end
      S_LD3: begin step_d = 4'd3; grb_d = 1'b1; ba_out_d = 1'b1; re_d[19] = 1'b1; end
      S_LD4: begin step_d = 4'd4; bs_d[23] = 1'b1; alu_d = ALU_ADD; re_d[18] = 1'b1; end
      S_LD5: begin step_d = 4'd5; bs_d[19] = 1'b1; re_d[25] = 1'b1; end
      S_LD6: begin step_d = 4'd6; md_read_d = 1'b1; read_ram_d = 1'b1; re_d[21] = 1'b1; end
      S_LD7: begin step_d = 4'd7; bs_d[21] = 1'b1; gra_d = 1'b1; rin_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_select <= '0; re_q <= '0; alu_op <= '0; step <= 4'hF;
      gra <= 1'b0; grb <= 1'b0; rin <= 1'b0; rout <= 1'b0; ba_out <= 1'b0;
      md_read <= 1'b0; read_ram <= 1'b0; halted <= 1'b0; fault <= 1'b0;
    end else begin
      bus_select <= bs_d; re_q <= re_d; alu_op <= alu_d; step <= step_d;
      gra <= gra_d; grb <= grb_d; rin <= rin_d; rout <= rout_d; ba_out <= ba_out_d;
      md_read <= md_read_d; read_ram <= read_ram_d;
      halted <= (next_state == S_HALT);
      fault  <= (next_state == S_FAULT);
    end
  end

  // PC load during fetch is held off until the RAM data is valid, so the
  // PC advances exactly once however long T1 stalls.
  always_comb begin
    reg_enable = re_q;
    if (state == S_T1 && !mem_ready) reg_enable[20] = 1'b0;
  end

endmodule
